multicycle_control_unit: RTL

- Next-generation RV32I control unit for the multicycle datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Sits between the instruction register and the shared ALU, register file and unified memory datapath.
- Adds JALR, LUI, AUIPC and all six branch conditions.
- Adds a memory ready handshake and illegal-instruction trapping.
- Widens ALUControl to cover shifts, XOR and SLTU.

---
 rtl/rv_ctrl_pkg.sv | 116 +++++++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
//   Shared definitions for the RV32I multicycle control unit: FSM state
//   encoding, base opcodes, ALU operation codes, datapath mux encodings and
//   small decode helpers used by the controller and its ALU decoder.
package rv_ctrl_pkg;

   // FSM states. The encoding is exported on state_dbg.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALRC    = 4'd11,
      ST_UEXEC    = 4'd12,
      ST_TRAP     = 4'd13
   } state_t;

   // Operand class seen by the ALU decoder.
   typedef enum logic {
      ALU_CLASS_R = 1'b0,
      ALU_CLASS_I = 1'b1
   } alu_class_t;

   // Base opcodes (instruction[6:0]).
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU operation codes (low four bits of ALUControl).
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   // Immediate formats.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU A operand select.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU B operand select.
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select.
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate format needed while decoding; DECODE precomputes the
   // branch/JAL target, so B and J matter there as much as I/S/U.
   function automatic logic [2:0] imm_for_opcode(input logic [6:0] op);
      logic [2:0] imm;
      imm = IMM_I;
      case (op)
         OP_STORE:         imm = IMM_S;
         OP_BRANCH:        imm = IMM_B;
         OP_JAL:           imm = IMM_J;
         OP_LUI, OP_AUIPC: imm = IMM_U;
         default:          imm = IMM_I;
      endcase
      return imm;
   endfunction

   // funct3 values 010/011 are not defined for conditional branches.
   function automatic logic branch_funct3_legal(input logic [2:0] funct3);
      return !((funct3 == 3'b010) || (funct3 == 3'b011));
   endfunction

   // Branch resolution from the comparator flags of rs1 - rs2.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic zero_flg,
                                         input logic lt_flg,
                                         input logic ltu_flg);
      logic taken;
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero_flg;
         3'b001:  taken = !zero_flg;
         3'b100:  taken = lt_flg;
         3'b101:  taken = !lt_flg;
         3'b110:  taken = ltu_flg;
         3'b111:  taken = !ltu_flg;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder
//   Combinational funct3/funct7 decode to a 4-bit ALU operation code.
//   Ports:
//     alu_class  in   R-type or I-type arithmetic
//     funct3     in   instruction[14:12]
//     funct7     in   instruction[31:25] (imm[11:5] for I-type)
//     alu_code   out  ALU operation
//     illegal    out  R-type with an undefined funct7 encoding
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   output logic [3:0]  alu_code,
   output logic        illegal
);

   logic is_r;
   assign is_r = (alu_class == ALU_CLASS_R);

   always_comb begin
      alu_code = ALU_ADD;
      illegal  = 1'b0;

      case (funct3)
         // ADDI has no SUB form, so imm bit 10 must not turn it into SUB.
         3'b000: alu_code = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001: alu_code = ALU_SLL;
         3'b010: alu_code = ALU_SLT;
         3'b011: alu_code = ALU_SLTU;
         3'b100: alu_code = ALU_XOR;
         3'b101: alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110: alu_code = ALU_OR;
         3'b111: alu_code = ALU_AND;
         default: alu_code = ALU_ADD;
      endcase

      // Only 0000000 everywhere and 0100000 for SUB/SRA are defined.
      if (is_r) begin
         if (funct7 == 7'b0000000) begin
            illegal = 1'b0;
         end else if ((funct7 == 7'b0100000) &&
                      ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
            illegal = 1'b0;
         end else begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore FSM sequencing the RV32I multicycle datapath through fetch,
//   decode, execute, memory and writeback.
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     instruction         IR contents, valid from DECODE onward
//     mem_ready           memory access complete
//     zero_flg/lt_flg/ltu_flg  comparator flags for branches
//     PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//     ALUSrcA, ALUSrcB, ImmSrc, RegWrite   datapath controls
//     illegal             high while parked in TRAP
//     state_dbg           current state encoding
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W      = 4,
   parameter int MEM_HANDSHAKE   = 1,
   parameter int TRAP_ON_ILLEGAL = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           instruction,
   input  logic                  mem_ready,
   input  logic                  zero_flg,
   input  logic                  lt_flg,
   input  logic                  ltu_flg,
   output logic                  PCWrite,
   output logic                  AdrSrc,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic [1:0]            ResultSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [2:0]            ImmSrc,
   output logic                  RegWrite,
   output logic                  illegal,
   output logic [3:0]            state_dbg
);

   state_t state_reg;
   state_t state_next;
   state_t decode_next;
   state_t trap_dest;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       mem_ok;

   alu_class_t dec_class;
   logic [3:0] dec_alu_code;
   logic       dec_illegal;

   logic       pc_write_raw;
   logic       mem_write_raw;
   logic       ir_write_raw;
   logic       reg_write_raw;
   logic [3:0] alu_code;

   // Register and immediate fields are the datapath's business.
   logic unused_fields;
   assign unused_fields = ^{instruction[24:15], instruction[11:7]};

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];

   // Without the handshake every memory access completes in one cycle.
   assign mem_ok    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign trap_dest = (TRAP_ON_ILLEGAL != 0) ? ST_TRAP : ST_FETCH;
   assign dec_class = (opcode == OP_RTYPE) ? ALU_CLASS_R : ALU_CLASS_I;

   alu_decoder u_alu_decoder (
      .alu_class (dec_class),
      .funct3    (funct3),
      .funct7    (funct7),
      .alu_code  (dec_alu_code),
      .illegal   (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Illegal encodings are caught while still in DECODE so that no
   // execute state with side effects is ever entered for them.
   always_comb begin
      decode_next = trap_dest;
      case (opcode)
         OP_LOAD, OP_STORE: decode_next = ST_MEMADR;
         OP_RTYPE:          decode_next = dec_illegal ? trap_dest : ST_EXECR;
         OP_ITYPE:          decode_next = ST_EXECI;
         OP_BRANCH:         decode_next = branch_funct3_legal(funct3) ?
                                          ST_BRANCH : trap_dest;
         OP_JAL:            decode_next = ST_JAL;
         OP_JALR:           decode_next = ST_JALRC;
         OP_LUI, OP_AUIPC:  decode_next = ST_UEXEC;
         default:           decode_next = trap_dest;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      pc_write_raw  = 1'b0;
      AdrSrc        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      ResultSrc     = RES_ALUOUT;
      alu_code      = ALU_ADD;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RS2;
      ImmSrc        = IMM_I;
      reg_write_raw = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURESULT;
            ir_write_raw = mem_ok;
            pc_write_raw = mem_ok;
            if (mem_ok) begin
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = imm_for_opcode(opcode);
            state_next = decode_next;
         end
         ST_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            if (opcode == OP_STORE) begin
               ImmSrc     = IMM_S;
               state_next = ST_MEMWRITE;
            end else begin
               ImmSrc     = IMM_I;
               state_next = ST_MEMREAD;
            end
         end
         ST_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ok) begin
               state_next = ST_MEMWB;
            end
         end
         ST_MEMWB: begin
            ResultSrc     = RES_DATA;
            reg_write_raw = 1'b1;
            state_next    = ST_FETCH;
         end
         ST_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ok) begin
               state_next = ST_FETCH;
            end
         end
         ST_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            alu_code   = dec_alu_code;
            state_next = ST_ALUWB;
         end
         ST_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            alu_code   = dec_alu_code;
            state_next = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_write_raw = 1'b1;
            state_next    = ST_FETCH;
         end
         ST_BRANCH: begin
            ALUSrcA      = SRCA_RS1;
            ALUSrcB      = SRCB_RS2;
            alu_code     = ALU_SUB;
            // Target was computed into ALUOut during DECODE.
            pc_write_raw = branch_taken(funct3, zero_flg, lt_flg, ltu_flg);
            state_next   = ST_FETCH;
         end
         ST_JALRC: begin
            // rs1 + imm lands in ALUOut; JAL then loads it into the PC.
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            state_next = ST_JAL;
         end
         ST_JAL: begin
            // PC <- ALUOut while the ALU forms the link value OldPC + 4.
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            pc_write_raw = 1'b1;
            state_next   = ST_ALUWB;
         end
         ST_UEXEC: begin
            ImmSrc     = IMM_U;
            ALUSrcB    = SRCB_IMM;
            ALUSrcA    = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            state_next = ST_ALUWB;
         end
         ST_TRAP: begin
            state_next = ST_TRAP;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // FETCH strobes follow mem_ready, so they are gated by rst_n to stay
   // low for the whole time reset is held.
   assign PCWrite  = pc_write_raw & rst_n;
   assign IRWrite  = ir_write_raw & rst_n;
   assign MemWrite = mem_write_raw & rst_n;
   assign RegWrite = reg_write_raw & rst_n;

   assign illegal   = (state_reg == ST_TRAP);
   assign state_dbg = state_reg;

   always_comb begin
      ALUControl      = '0;
      ALUControl[3:0] = alu_code;
   end

endmodule
